// File: rtl/ram_arbiter.sv
// Two-master arbiter for a 1W/1R combinational-read data RAM: round-robin with a
// bounded master-1 lock, RAM port drive and one-cycle registered read responses.
module ram_arbiter #(
  parameter int DEPTH    = 128,
  parameter int MAX_HOLD = 16,
  parameter int AW       = 16,
  parameter int DW       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_err,
  output logic [AW-1:0] mem_waddr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_raddr_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic [1:0]    dbg_state
);

  // Handshake: an access completes in the cycle where req and gnt are both high;
  // an ungranted master holds req/we/addr/wdata stable until it is granted.

  typedef enum logic [1:0] {ST_RR = 2'd0, ST_LOCK1 = 2'd1, ST_FORCE0 = 2'd2} state_t;

  localparam logic [AW:0] DEPTH_L    = (AW + 1)'(DEPTH);
  localparam logic [7:0]  MAX_HOLD_L = 8'(MAX_HOLD);

  state_t        state;
  logic          last;
  logic [7:0]    hold_cnt;
  logic [7:0]    hold_inc;
  logic          gnt0;
  logic          gnt1;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          in_range;

  // Grants are masked by rst_n so nothing reaches the RAM while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      unique case (state)
        ST_RR: begin
          if (m0_req && m1_req) begin
            gnt0 = last;
            gnt1 = !last;
          end else begin
            gnt0 = m0_req;
            gnt1 = m1_req;
          end
        end
        ST_LOCK1:  gnt1 = m1_req;
        ST_FORCE0: gnt0 = m0_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt1) begin
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end else if (gnt0) begin
      sel_we    = m0_we;
      sel_addr  = m0_addr;
      sel_wdata = m0_wdata;
    end
  end

  assign in_range    = {1'b0, sel_addr} < DEPTH_L;
  assign m0_gnt      = gnt0;
  assign m1_gnt      = gnt1;
  assign mem_waddr_o = sel_addr;
  assign mem_raddr_o = sel_addr;
  assign mem_wdata_o = sel_wdata;
  assign mem_we_o    = (gnt0 || gnt1) && sel_we && in_range;
  assign dbg_state   = state;
  assign hold_inc    = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RR;
      last     <= 1'b1;
      hold_cnt <= 8'd0;
    end else begin
      unique case (state)
        ST_RR: begin
          if (gnt0) last <= 1'b0;
          if (gnt1) begin
            last <= 1'b1;
            if (m1_lock) begin
              hold_cnt <= 8'd1;
              // A hold limit of one already expires on the opening grant.
              state    <= (MAX_HOLD_L <= 8'd1 && m0_req) ? ST_FORCE0 : ST_LOCK1;
            end
          end
        end
        ST_LOCK1: begin
          if (!m1_req) begin
            state    <= ST_RR;
            hold_cnt <= 8'd0;
          end else begin
            last     <= 1'b1;
            hold_cnt <= hold_inc;
            if (hold_inc >= MAX_HOLD_L && m0_req) begin
              state <= ST_FORCE0;
            end else if (!m1_lock) begin
              state    <= ST_RR;
              hold_cnt <= 8'd0;
            end
          end
        end
        ST_FORCE0: begin
          state    <= ST_RR;
          last     <= 1'b0;
          hold_cnt <= 8'd0;
        end
        default: state <= ST_RR;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_rvalid <= 1'b0;
      m1_err    <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= gnt0 && !m0_we;
      m0_err    <= gnt0 && !in_range;
      m1_rvalid <= gnt1 && !m1_we;
      m1_err    <= gnt1 && !in_range;
      if (gnt0 && !m0_we) m0_rdata <= in_range ? mem_rdata_i : '0;
      if (gnt1 && !m1_we) m1_rdata <= in_range ? mem_rdata_i : '0;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, arbitration/memory reference model and
// read-data scoreboard, driven by directed scenarios plus randomized traffic.
module tb_ram_arbiter;

  localparam int DEPTH    = 128;
  localparam int MAX_HOLD = 16;
  localparam int AW       = 16;
  localparam int DW       = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] mem_waddr_o, mem_raddr_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;
  logic          mem_we_o;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.DEPTH(DEPTH), .MAX_HOLD(MAX_HOLD), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
    .mem_raddr_o(mem_raddr_o), .mem_rdata_i(mem_rdata_i), .dbg_state(dbg_state)
  );

  // ---------------- clock / RAM ----------------
  always #5 clk = ~clk;

  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) if (mem_we_o) ram[mem_waddr_o[6:0]] <= mem_wdata_o;
  // Out-of-range reads see garbage so the arbiter must zero them itself.
  assign mem_rdata_i = (mem_raddr_o < AW'(DEPTH)) ? ram[mem_raddr_o[6:0]] : 32'hBAD0_BAD0;

  // ---------------- reference model ----------------
  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] exp_q[$];
  int  md_last;     // master that won most recently
  bit  md_locked;   // master 1 owns the RAM
  bit  md_force;    // master 0's guaranteed turn after an expired hold
  int  md_burst;    // master-1 grants in the current locked run
  bit  mg0, mg1;    // model grants of the last cycle
  bit  obs_g0, obs_g1, obs_we;

  task automatic model_reset();
    md_last = 1; md_locked = 0; md_force = 0; md_burst = 0;
    mg0 = 0; mg1 = 0;
    exp_q.delete();
  endtask

  // One clock: predict grants, check the combinational side, then check the
  // registered response after the edge. Caller sets inputs at posedge+1.
  task automatic cycle();
    bit g0, g1, inr, ev0, ev1, ee0, ee1;
    logic [AW-1:0] a;
    logic we_s;
    logic [DW-1:0] wd, rd;
    #1;
    g0 = 0; g1 = 0;
    if (md_force) g0 = m0_req;
    else if (md_locked) g1 = m1_req;
    else if (m0_req && m1_req) begin g0 = (md_last == 1); g1 = (md_last == 0); end
    else begin g0 = m0_req; g1 = m1_req; end
    obs_g0 = m0_gnt; obs_g1 = m1_gnt; obs_we = mem_we_o;
    checks++;
    if (m0_gnt !== g0 || m1_gnt !== g1) begin
      errors++;
      $display("FAIL gnt: got m0=%b m1=%b, want m0=%b m1=%b", m0_gnt, m1_gnt, g0, g1);
    end
    a = g1 ? m1_addr : m0_addr;
    we_s = g1 ? m1_we : m0_we;
    wd = g1 ? m1_wdata : m0_wdata;
    inr = (a < DEPTH);
    checks++;
    if (mem_we_o !== ((g0 || g1) && we_s && inr)) begin
      errors++;
      $display("FAIL mem_we: got %b want %b", mem_we_o, (g0 || g1) && we_s && inr);
    end
    if (g0 || g1) begin
      checks++;
      if (mem_raddr_o !== a || mem_waddr_o !== a || (we_s && mem_wdata_o !== wd)) begin
        errors++;
        $display("FAIL mem_drive: got ra=%0d wa=%0d wd=%h want a=%0d wd=%h",
                 mem_raddr_o, mem_waddr_o, mem_wdata_o, a, wd);
      end
    end
    ev0 = g0 && !m0_we; ev1 = g1 && !m1_we;
    ee0 = g0 && !inr;   ee1 = g1 && !inr;
    if (ev0 || ev1) begin
      rd = inr ? exp_mem[a[6:0]] : '0;
      exp_q.push_back(rd);
    end
    if ((g0 || g1) && we_s && inr) exp_mem[a[6:0]] = wd;
    // arbitration rules
    if (md_force) begin
      md_force = 0; md_last = 0; md_burst = 0;
    end else if (md_locked) begin
      if (!m1_req) begin md_locked = 0; md_burst = 0; end
      else begin
        md_burst++; md_last = 1;
        if (md_burst >= MAX_HOLD && m0_req) begin md_locked = 0; md_force = 1; end
        else if (!m1_lock) begin md_locked = 0; md_burst = 0; end
      end
    end else begin
      if (g0) md_last = 0;
      if (g1) begin
        md_last = 1;
        if (m1_lock) begin
          md_burst = 1;
          if (md_burst >= MAX_HOLD && m0_req) md_force = 1; else md_locked = 1;
        end
      end
    end
    mg0 = g0; mg1 = g1;
    @(posedge clk); #1;
    checks++;
    if (m0_rvalid !== ev0 || m1_rvalid !== ev1) begin
      errors++;
      $display("FAIL rvalid: got m0=%b m1=%b want m0=%b m1=%b", m0_rvalid, m1_rvalid, ev0, ev1);
    end
    checks++;
    if (m0_err !== ee0 || m1_err !== ee1) begin
      errors++;
      $display("FAIL err: got m0=%b m1=%b want m0=%b m1=%b", m0_err, m1_err, ee0, ee1);
    end
    if ((ev0 || ev1) && exp_q.size() > 0) begin
      rd = exp_q.pop_front();
      checks++;
      if ((ev0 ? m0_rdata : m1_rdata) !== rd) begin
        errors++;
        $display("FAIL rdata: got %h want %h", ev0 ? m0_rdata : m1_rdata, rd);
      end
    end
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_lock = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    m0_req = 1; m0_we = 1; m0_addr = 16'd4; m0_wdata = 32'h1234_5678;
    #1;
    checks++;
    if (m0_gnt !== 1'b0 || mem_we_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_gnt: got gnt=%b we=%b want 0 0", m0_gnt, mem_we_o);
    end
    checks++;
    if (m0_rvalid !== 0 || m1_rvalid !== 0 || m0_err !== 0 || m1_err !== 0 ||
        m0_rdata !== '0 || m1_rdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rv=%b%b err=%b%b rd0=%h rd1=%h want zeros",
               m0_rvalid, m1_rvalid, m0_err, m1_err, m0_rdata, m1_rdata);
    end
    do_reset();
  endtask

  task automatic test_write_read();
    m0_req = 1; m0_we = 1; m0_addr = 16'd5; m0_wdata = 32'hDEAD_BEEF;
    cycle();
    checks++;
    if (obs_g0 !== 1 || obs_we !== 1) begin
      errors++; $display("FAIL wr_grant: got gnt=%b we=%b want 1 1", obs_g0, obs_we);
    end
    m0_we = 0; m0_wdata = '0;
    cycle();
    checks++;
    if (obs_g0 !== 1 || obs_we !== 0 || m0_rvalid !== 1 || m0_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_back: got gnt=%b we=%b rv=%b rd=%h want 1 0 1 deadbeef",
               obs_g0, obs_we, m0_rvalid, m0_rdata);
    end
    idle_inputs();
    cycle();
    checks++;
    if (m0_rvalid !== 0 || m0_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL rdata_hold: got rv=%b rd=%h want 0 deadbeef", m0_rvalid, m0_rdata);
    end
  endtask

  task automatic test_alternate();
    do_reset();
    m0_req = 1; m0_addr = 16'd10; m1_req = 1; m1_addr = 16'd11;
    for (int i = 0; i < 8; i++) begin
      cycle();
      checks++;
      if (obs_g0 !== (i % 2 == 0) || obs_g1 !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL alternate[%0d]: got m0=%b m1=%b want m0=%b", i, obs_g0, obs_g1, i % 2 == 0);
      end
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_lock_burst();
    int k = 0, run = 0, first_run = -1, cyc = 0;
    bit resumed = 0, saw_m0 = 0;
    m1_req = 1; m1_we = 1; m1_lock = 1; m1_addr = 16'd20; m1_wdata = $urandom;
    while (k < 20 && cyc < 60) begin
      if (cyc == 1) begin m0_req = 1; m0_we = 0; m0_addr = 16'd9; end
      cycle();
      cyc++;
      if (obs_g1) run++;
      if (saw_m0 && first_run >= 0 && !resumed) resumed = obs_g1;
      if (obs_g0 && !saw_m0) begin first_run = run; saw_m0 = 1; m0_req = 0; end
      if (obs_g1) begin
        k++;
        m1_addr = AW'(20 + k); m1_wdata = $urandom;
      end
    end
    checks++;
    if (k != 20) begin errors++; $display("FAIL burst_done: got %0d writes want 20", k); end
    checks++;
    if (first_run != MAX_HOLD) begin
      errors++; $display("FAIL burst_hold: got %0d m1 grants before m0, want %0d", first_run, MAX_HOLD);
    end
    checks++;
    if (!resumed) begin errors++; $display("FAIL burst_resume: got 0 want 1"); end
    idle_inputs();
    cycle();
  endtask

  task automatic test_lock_release();
    m1_req = 1; m1_we = 0; m1_lock = 1; m1_addr = 16'd1;
    cycle();
    m0_req = 1; m0_we = 0; m0_addr = 16'd2;
    for (int i = 0; i < 2; i++) begin
      cycle();
      checks++;
      if (obs_g1 !== 1 || obs_g0 !== 0) begin
        errors++; $display("FAIL lock_hold[%0d]: got m0=%b m1=%b want 0 1", i, obs_g0, obs_g1);
      end
    end
    m1_req = 0; m1_lock = 0;
    cycle();
    checks++;
    if (obs_g0 !== 0) begin errors++; $display("FAIL lock_release_cycle: got m0=%b want 0", obs_g0); end
    cycle();
    checks++;
    if (obs_g0 !== 1) begin errors++; $display("FAIL lock_after_release: got m0=%b want 1", obs_g0); end
    idle_inputs();
    cycle();
  endtask

  task automatic test_out_of_range();
    m0_req = 1; m0_we = 1; m0_addr = 16'd200; m0_wdata = 32'h1;
    cycle();
    checks++;
    if (obs_g0 !== 1 || obs_we !== 0 || m0_err !== 1) begin
      errors++; $display("FAIL oor_write: got gnt=%b we=%b err=%b want 1 0 1", obs_g0, obs_we, m0_err);
    end
    m0_we = 0;
    cycle();
    checks++;
    if (m0_rvalid !== 1 || m0_rdata !== '0 || m0_err !== 1) begin
      errors++; $display("FAIL oor_read: got rv=%b rd=%h err=%b want 1 0 1", m0_rvalid, m0_rdata, m0_err);
    end
    idle_inputs();
    cycle();
    checks++;
    if (m0_err !== 0) begin errors++; $display("FAIL oor_err_pulse: got %b want 0", m0_err); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (!(m0_req && !mg0)) begin
        m0_req = ($urandom_range(0, 3) != 0); m0_we = $urandom_range(0, 1);
        m0_addr = AW'($urandom_range(0, 140)); m0_wdata = $urandom;
      end
      if (!(m1_req && !mg1)) begin
        m1_req = ($urandom_range(0, 2) != 0); m1_we = $urandom_range(0, 1);
        m1_addr = AW'($urandom_range(0, 140)); m1_wdata = $urandom;
      end
      m1_lock = ($urandom_range(0, 9) < 8);
      cycle();
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_reset_mid_lock();
    m1_req = 1; m1_we = 0; m1_lock = 1; m1_addr = 16'd3;
    cycle();
    m0_req = 1; m0_we = 0; m0_addr = 16'd6; m1_addr = 16'd130;
    cycle();
    rst_n = 0;
    #1;
    checks++;
    if (m1_rvalid !== 0 || m1_err !== 0 || m1_rdata !== '0 || m1_gnt !== 0 || mem_we_o !== 0) begin
      errors++;
      $display("FAIL reset_mid_lock: got rv=%b err=%b rd=%h gnt=%b we=%b want zeros",
               m1_rvalid, m1_err, m1_rdata, m1_gnt, mem_we_o);
    end
    @(posedge clk); #3;
    rst_n = 1;
    model_reset();
    m1_addr = 16'd7; m1_lock = 0;
    cycle();
    checks++;
    if (obs_g0 !== 1 || obs_g1 !== 0) begin
      errors++; $display("FAIL reset_first_conflict: got m0=%b m1=%b want 1 0", obs_g0, obs_g1);
    end
    idle_inputs();
    cycle();
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = 32'hA5A5_0000 + 32'(i * 7);
      exp_mem[i] = 32'hA5A5_0000 + 32'(i * 7);
    end
    model_reset();
    #2;
    test_reset();
    test_write_read();
    test_alternate();
    test_lock_burst();
    test_lock_release();
    test_out_of_range();
    test_random();
    test_reset_mid_lock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter/sequencer for the single-write-port, single-read-port, combinational-read data RAM.
- Master 0 is the core load/store unit. Master 1 is the boot loader / debug port.
- Grants at most one access per cycle, round-robin with an optional bounded lock for master 1 bursts.
- Drives the RAM address, data and write-enable, and returns registered read data with a one-cycle response.

Parameters:
- DEPTH, 128, number of 32-bit RAM words; addresses >= DEPTH are out of range.
- MAX_HOLD, 16, max consecutive cycles master 1 may keep the RAM via lock (1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  master 0 access request
- m0_we  in  1  master 0 write (1) / read (0)
- m0_addr  in  MemAddrBus  master 0 word address
- m0_wdata  in  MemBus  master 0 write data
- m0_gnt  out  1  master 0 access accepted this cycle
- m0_rvalid  out  1  master 0 read data valid
- m0_rdata  out  MemBus  master 0 read data
- m0_err  out  1  master 0 out-of-range access, pulsed with response timing
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as master 0, for master 1
- m1_lock  in  1  master 1 requests to keep ownership on following cycles
- mem_waddr_o  out  MemAddrBus  RAM write address
- mem_wdata_o  out  MemBus  RAM write data
- mem_we_o  out  1  RAM write enable
- mem_raddr_o  out  MemAddrBus  RAM read address
- mem_rdata_i  in  MemBus  RAM combinational read data

Behaviour:
- Handshake
  - An access completes in the cycle where mX_req=1 and mX_gnt=1.
  - gnt is combinational from req and state. At most one gnt is high per cycle.
  - A master that is not granted holds req, we, addr and wdata stable until granted.
- Arbitration state: FSM {RR, LOCK1, FORCE0}, plus a 1-bit last-winner pointer `last` and an 8-bit hold counter.
- RR state
  - Only one requester: it wins.
  - Both requesting: the master != `last` wins.
  - `last` updates on every grant.
  - Reset: state=RR, `last`=1, so master 0 wins the first conflict.
- RR -> LOCK1: master 1 is granted with m1_lock=1; hold counter := 1.
- LOCK1 state
  - Master 1 is granted whenever m1_req=1. Master 0 gets no grant.
  - Each m1 grant increments the counter.
  - Exit to RR when m1_lock=0 or m1_req=0 (cycle with no access).
  - If counter reaches MAX_HOLD and m0_req=1, go to FORCE0.
- FORCE0 state: master 0 is granted if requesting, else no grant. Always returns to RR with `last`=0.
- RAM drive
  - The granted master's addr is driven on both mem_raddr_o and mem_waddr_o, and its wdata on mem_wdata_o.
  - mem_we_o = gnt & we & in-range.
  - With no grant: addresses and data = 0, mem_we_o = 0.
  - A write commits at the granting clock edge.
- Read response
  - Granted read: mem_rdata_i is captured at that edge into mX_rdata, and mX_rvalid=1 for exactly the next cycle. Latency is 1.
  - mX_rdata holds its value after rvalid drops.
- Out of range (addr >= DEPTH)
  - Write is suppressed.
  - A read returns rdata=0 with rvalid=1.
  - mX_err=1 in the cycle after the grant, for reads and writes.
- Back-to-back accesses by the same master produce rvalid on consecutive cycles.
- Reset (asynchronous, any time, including mid-lock)
  - All rvalid, err and rdata = 0. state=RR, `last`=1, counter=0.
  - gnt and mem_* outputs follow the reset state combinationally: no write occurs while rst_n=0.

Test Plan:
- Reset, then m0 writes addr 5 = 0xDEADBEEF, next cycle reads addr 5 -> m0_gnt both cycles, mem_we_o=1 once, m0_rvalid=1 one cycle after the read grant with m0_rdata=0xDEADBEEF.
- m0 and m1 request reads continuously from the same cycle after reset -> grants alternate m0,m1,m0,m1; each rvalid follows its grant by 1 cycle; never two gnts in one cycle.
- m1 locked burst of 20 writes with m0_req held high, MAX_HOLD=16 -> m1 granted 16 consecutive cycles, m0 granted the next cycle, m1 resumes after.
- m1 lock for 3 cycles then m1_lock=0 with m0 waiting -> m0 granted on the cycle after m1 releases.
- m0 write to addr 200 with data 0x1 -> mem_we_o=0, m0_err=1 the next cycle; a read of addr 200 -> rvalid=1, rdata=0, err=1.
- rst_n asserted mid-lock with a pending read response -> rvalid and err drop immediately, m0 wins the first conflict after reset release.
